// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ROB ids at dispatch, captures CDB results,
// retires in program order and flushes the machine on a committed mispredicted jump.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_ID_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,

    input  logic                issue_en,
    input  logic [4:0]          issue_rd,
    input  logic                issue_is_jump,
    input  logic                issue_pred_jump,
    input  logic [31:0]         issue_pc,
    input  logic [31:0]         issue_rollback_pc,
    output logic [ROB_ID_W-1:0] next_rob_id,
    output logic                full,

    input  logic [ROB_ID_W-1:0] q1_in,
    input  logic [ROB_ID_W-1:0] q2_in,
    output logic                q1_ready,
    output logic                q2_ready,
    output logic [31:0]         v1_out,
    output logic [31:0]         v2_out,

    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [31:0]         alu_data,
    input  logic                alu_jump,
    input  logic                ls_valid,
    input  logic [ROB_ID_W-1:0] ls_rob_id,
    input  logic [31:0]         ls_data,

    output logic                commit_en,
    output logic [4:0]          commit_rd,
    output logic [31:0]         commit_data,
    output logic [ROB_ID_W-1:0] commit_rob_id,
    output logic                rollback_out,
    output logic [31:0]         rollback_pc_out,
    output logic                bp_update_en,
    output logic [31:0]         bp_pc,
    output logic                bp_taken
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // ROB id is index+1 so that id 0 can mean "no producer".
    function automatic logic id_ok(input logic [ROB_ID_W-1:0] id);
        return (id != '0) && (id <= ROB_ID_W'(ROB_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] id2idx(input logic [ROB_ID_W-1:0] id);
        logic [ROB_ID_W-1:0] t;
        t = id - ROB_ID_W'(1);
        return t[IDX_W-1:0];
    endfunction

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        valid_q   [ROB_DEPTH];
    logic        valid_d   [ROB_DEPTH];
    logic        ready_q   [ROB_DEPTH];
    logic        ready_d   [ROB_DEPTH];
    logic [4:0]  rd_q      [ROB_DEPTH];
    logic [4:0]  rd_d      [ROB_DEPTH];
    logic [31:0] value_q   [ROB_DEPTH];
    logic [31:0] value_d   [ROB_DEPTH];
    logic        is_jump_q [ROB_DEPTH];
    logic        is_jump_d [ROB_DEPTH];
    logic        pred_q    [ROB_DEPTH];
    logic        pred_d    [ROB_DEPTH];
    logic        actual_q  [ROB_DEPTH];
    logic        actual_d  [ROB_DEPTH];
    logic [31:0] pc_q      [ROB_DEPTH];
    logic [31:0] pc_d      [ROB_DEPTH];
    logic [31:0] rb_pc_q   [ROB_DEPTH];
    logic [31:0] rb_pc_d   [ROB_DEPTH];

    logic                commit_en_q, commit_en_d;
    logic [4:0]          commit_rd_q, commit_rd_d;
    logic [31:0]         commit_data_q, commit_data_d;
    logic [ROB_ID_W-1:0] commit_rob_id_q, commit_rob_id_d;
    logic                rollback_q, rollback_d;
    logic [31:0]         rollback_pc_q, rollback_pc_d;
    logic                bp_update_en_q, bp_update_en_d;
    logic [31:0]         bp_pc_q, bp_pc_d;
    logic                bp_taken_q, bp_taken_d;

    logic             commit_fire, mispredict, alu_hit, ls_hit, issue_acc;
    logic [IDX_W-1:0] alu_idx, ls_idx;

    assign alu_idx = id2idx(alu_rob_id);
    assign ls_idx  = id2idx(ls_rob_id);

    // Commit decision uses registered ready, so a result landing this cycle retires next cycle.
    assign commit_fire = valid_q[head_q] && ready_q[head_q];
    assign mispredict  = commit_fire && is_jump_q[head_q] && (actual_q[head_q] != pred_q[head_q]);

    // The cycle after a flush carries wrong-path traffic and is dropped.
    assign alu_hit = !rollback_q && alu_valid && id_ok(alu_rob_id) && valid_q[alu_idx];
    assign ls_hit  = !rollback_q && ls_valid && id_ok(ls_rob_id) && valid_q[ls_idx];

    // A slot freed by this cycle's commit may be reused by this cycle's issue.
    assign issue_acc = issue_en && !rollback_q && !mispredict &&
                       ((count_q < CNT_W'(ROB_DEPTH)) || commit_fire);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
        rd_d      = rd_q;
        value_d   = value_q;
        is_jump_d = is_jump_q;
        pred_d    = pred_q;
        actual_d  = actual_q;
        pc_d      = pc_q;
        rb_pc_d   = rb_pc_q;

        commit_en_d     = 1'b0;
        commit_rd_d     = commit_rd_q;
        commit_data_d   = commit_data_q;
        commit_rob_id_d = commit_rob_id_q;
        rollback_d      = 1'b0;
        rollback_pc_d   = rollback_pc_q;
        bp_update_en_d  = 1'b0;
        bp_pc_d         = bp_pc_q;
        bp_taken_d      = bp_taken_q;

        if (alu_hit) begin
            value_d[alu_idx]  = alu_data;
            actual_d[alu_idx] = alu_jump;
            ready_d[alu_idx]  = 1'b1;
        end
        if (ls_hit) begin
            value_d[ls_idx]  = ls_data;
            actual_d[ls_idx] = 1'b0;
            ready_d[ls_idx]  = 1'b1;
        end

        if (commit_fire) begin
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
            commit_en_d     = 1'b1;
            commit_rd_d     = rd_q[head_q];
            commit_data_d   = value_q[head_q];
            commit_rob_id_d = ROB_ID_W'(head_q) + 1'b1;
            if (is_jump_q[head_q]) begin
                bp_update_en_d = 1'b1;
                bp_pc_d        = pc_q[head_q];
                bp_taken_d     = actual_q[head_q];
            end
        end

        // Placed after the commit clear so a same-slot reuse at count==DEPTH keeps the new entry.
        if (issue_acc) begin
            valid_d[tail_q]   = 1'b1;
            ready_d[tail_q]   = 1'b0;
            rd_d[tail_q]      = issue_rd;
            is_jump_d[tail_q] = issue_is_jump;
            pred_d[tail_q]    = issue_pred_jump;
            pc_d[tail_q]      = issue_pc;
            rb_pc_d[tail_q]   = issue_rollback_pc;
            tail_d            = tail_q + 1'b1;
        end

        count_d = count_q + CNT_W'(issue_acc) - CNT_W'(commit_fire);

        if (mispredict) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                valid_d[i] = 1'b0;
                ready_d[i] = 1'b0;
            end
            head_d        = head_q + 1'b1;
            tail_d        = head_q + 1'b1;
            count_d       = '0;
            rollback_d    = 1'b1;
            rollback_pc_d = rb_pc_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            valid_q         <= '{default: 1'b0};
            ready_q         <= '{default: 1'b0};
            rd_q            <= '{default: '0};
            value_q         <= '{default: '0};
            is_jump_q       <= '{default: 1'b0};
            pred_q          <= '{default: 1'b0};
            actual_q        <= '{default: 1'b0};
            pc_q            <= '{default: '0};
            rb_pc_q         <= '{default: '0};
            commit_en_q     <= 1'b0;
            commit_rd_q     <= '0;
            commit_data_q   <= '0;
            commit_rob_id_q <= '0;
            rollback_q      <= 1'b0;
            rollback_pc_q   <= '0;
            bp_update_en_q  <= 1'b0;
            bp_pc_q         <= '0;
            bp_taken_q      <= 1'b0;
        end else if (rdy) begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            valid_q         <= valid_d;
            ready_q         <= ready_d;
            rd_q            <= rd_d;
            value_q         <= value_d;
            is_jump_q       <= is_jump_d;
            pred_q          <= pred_d;
            actual_q        <= actual_d;
            pc_q            <= pc_d;
            rb_pc_q         <= rb_pc_d;
            commit_en_q     <= commit_en_d;
            commit_rd_q     <= commit_rd_d;
            commit_data_q   <= commit_data_d;
            commit_rob_id_q <= commit_rob_id_d;
            rollback_q      <= rollback_d;
            rollback_pc_q   <= rollback_pc_d;
            bp_update_en_q  <= bp_update_en_d;
            bp_pc_q         <= bp_pc_d;
            bp_taken_q      <= bp_taken_d;
        end
    end

    assign next_rob_id = ROB_ID_W'(tail_q) + 1'b1;
    assign full        = count_q >= CNT_W'(ROB_DEPTH - 1);

    // Lookups read registered state only; dispatch covers same-cycle CDB forwarding.
    assign q1_ready = id_ok(q1_in) && valid_q[id2idx(q1_in)] && ready_q[id2idx(q1_in)];
    assign q2_ready = id_ok(q2_in) && valid_q[id2idx(q2_in)] && ready_q[id2idx(q2_in)];
    assign v1_out   = id_ok(q1_in) ? value_q[id2idx(q1_in)] : 32'h0;
    assign v2_out   = id_ok(q2_in) ? value_q[id2idx(q2_in)] : 32'h0;

    assign commit_en       = commit_en_q;
    assign commit_rd       = commit_rd_q;
    assign commit_data     = commit_data_q;
    assign commit_rob_id   = commit_rob_id_q;
    assign rollback_out    = rollback_q;
    assign rollback_pc_out = rollback_pc_q;
    assign bp_update_en    = bp_update_en_q;
    assign bp_pc           = bp_pc_q;
    assign bp_taken        = bp_taken_q;

endmodule
